// File: rtl/alu_accum_reg_pkg.sv
// -----------------------------------------------------------------------------
// alu_accum_pkg
//   Shared types for the register-feedback ALU:
//     func_e  - 3-bit operation select presented on the Function input
//     state_e - control state of the sequential multiplier
//   plus a small decode helper used by the top level.
// -----------------------------------------------------------------------------
package alu_accum_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    MUL  = 3'd1,
    SHL  = 3'd2,
    HOLD = 3'd3,
    SHR  = 3'd4,
    LOAD = 3'd5,
    ACC  = 3'd6,
    CLR  = 3'd7
  } func_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

  // True for operations that write the result register on the accept edge
  // itself. MUL writes later, when the multiplier finishes; HOLD never writes.
  function automatic logic writes_result(func_e f);
    return !(f inside {MUL, HOLD});
  endfunction

endpackage : alu_accum_pkg

// File: rtl/alu_accum_reg_if.sv
// -----------------------------------------------------------------------------
// alu_accum_reg_if
//   Operand/handshake bundle between the switch/key front end and the ALU.
//     Data     A operand (DATA_W)
//     Function operation select (func_e)
//     Go       request; accepted on a posedge where Busy is low
//     Busy     multiply in progress
//     Done     one-cycle pulse: ALUout holds a freshly written result
//     ALUout   result register (2*DATA_W)
//     Ovf      sticky accumulate overflow
//   master: the requester (switches/keys, testbench)
//   slave : the ALU
// -----------------------------------------------------------------------------
interface alu_accum_reg_if
  import alu_accum_pkg::*;
#(
  parameter int DATA_W = 4
) ();

  logic [DATA_W-1:0]   Data;
  func_e               Function;
  logic                Go;
  logic                Busy;
  logic                Done;
  logic [2*DATA_W-1:0] ALUout;
  logic                Ovf;

  modport master (
    output Data, Function, Go,
    input  Busy, Done, ALUout, Ovf
  );

  modport slave (
    input  Data, Function, Go,
    output Busy, Done, ALUout, Ovf
  );

endinterface : alu_accum_reg_if

// File: rtl/alu_accum_reg_seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Unsigned shift-add multiplier, one partial product per clock.
//   Ports:
//     Clock, Reset_b  clock and synchronous active-low reset
//     start           launch a multiply (ignored while busy)
//     a, b            operands, captured on the start edge
//     busy            high for DATA_W cycles after the start edge
//     done            high in the last busy cycle; product is valid then
//     product         a*b, valid while done is high
//   Timing: start accepted at edge k, steps at edges k+1..k+DATA_W; the
//   consumer registers product at edge k+DATA_W, where busy also falls.
// -----------------------------------------------------------------------------
module seq_multiplier
  import alu_accum_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                Clock,
  input  logic                Reset_b,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [RES_W-1:0]  a_sh_q;   // multiplicand, shifted left once per step
  logic [DATA_W-1:0] b_sh_q;   // multiplier, LSB selects the current step
  logic [RES_W-1:0]  acc_q;    // running partial product
  logic [RES_W-1:0]  acc_step;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: datapath registers carry no reset; they are all loaded on the start
  // edge, and nothing reads them while the control FSM is idle.
  always_ff @(posedge Clock) begin
    if (state_q == IDLE && start) begin
      a_sh_q <= RES_W'(a);
      b_sh_q <= b;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == MUL_RUN) begin
      acc_q  <= acc_step;
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign acc_step = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  assign product  = acc_step;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = MUL_RUN;
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST_STEP) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule : seq_multiplier

// File: rtl/alu_accum_reg.sv
// -----------------------------------------------------------------------------
// alu_accum_reg
//   Register-feedback ALU for the lab datapath. Operand A comes from the
//   switches (bus.Data); operand B is the low DATA_W bits of the ALU's own
//   2*DATA_W result register. Single-cycle ops write on the accept edge; MUL
//   runs in seq_multiplier and writes DATA_W edges after acceptance.
//   Ports:
//     Clock    single clock, all state changes on posedge
//     Reset_b  synchronous active-low reset; clears result, Ovf, Done and
//              aborts a running multiply
//     bus      alu_accum_reg_if.slave (Data, Function, Go -> Busy, Done,
//              ALUout, Ovf)
// -----------------------------------------------------------------------------
module alu_accum_reg
  import alu_accum_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic           Clock,
  input  logic           Reset_b,
  alu_accum_reg_if.slave bus
);

  localparam int RES_W = 2 * DATA_W;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              accept;

  logic [RES_W-1:0]  alu_q, alu_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              wr_single;

  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [RES_W-1:0]  mul_product;

  logic [RES_W-1:0]  add_val;
  logic [RES_W:0]    acc_sum;   // MSB is the accumulate carry
  logic [RES_W-1:0]  shl_val;
  logic [RES_W-1:0]  shr_val;

  assign a         = bus.Data;
  assign b         = alu_q[DATA_W-1:0];
  assign accept    = bus.Go && !mul_busy;
  assign mul_start = accept && (bus.Function == MUL);

  seq_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // A+B has DATA_W+1 significant bits, so it always fits the result register.
  assign add_val = RES_W'(a) + RES_W'(b);
  assign acc_sum = {1'b0, alu_q} + (RES_W + 1)'(a);

  // Shift amounts of RES_W or more clear the register; spelled out so the
  // intent does not rest on shift-operator semantics.
  assign shl_val = (32'(a) >= RES_W) ? '0 : (RES_W'(b) << a);
  assign shr_val = (32'(a) >= RES_W) ? '0 : (alu_q >> a);

  always_comb begin
    alu_d     = alu_q;
    ovf_d     = ovf_q;
    wr_single = 1'b0;
    // A finishing multiply and an accept cannot coincide: accept needs Busy
    // low, and the multiplier only completes while Busy is high.
    if (mul_done) begin
      alu_d = mul_product;
    end else if (accept) begin
      wr_single = writes_result(bus.Function);
      unique case (bus.Function)
        ADD:  alu_d = add_val;
        SHL:  alu_d = shl_val;
        SHR:  alu_d = shr_val;
        LOAD: begin
          alu_d = RES_W'(a);
          ovf_d = 1'b0;
        end
        ACC: begin
          alu_d = acc_sum[RES_W-1:0];
          if (acc_sum[RES_W]) ovf_d = 1'b1;
        end
        CLR: begin
          alu_d = '0;
          ovf_d = 1'b0;
        end
        default: ;  // MUL launches the multiplier; HOLD does nothing
      endcase
    end
  end

  assign done_d = wr_single || mul_done;

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      alu_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign bus.ALUout = alu_q;
  assign bus.Ovf    = ovf_q;
  assign bus.Done   = done_q;
  assign bus.Busy   = mul_busy;

endmodule : alu_accum_reg

// File: tb/tb_alu_accum_reg.sv
// -----------------------------------------------------------------------------
// tb_alu_accum_reg
//   Directed bench for alu_accum_reg with DATA_W=4. A table of per-cycle
//   records (inputs + expected outputs after the edge) covers the main
//   operations; hand-written sequences cover reset during activity and reset
//   aborting a running multiply. Inputs change 1 time unit after posedge and
//   outputs are checked at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_alu_accum_reg;
  import alu_accum_pkg::*;

  localparam int DATA_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_accum_reg_if #(.DATA_W(DATA_W)) bus ();

  alu_accum_reg #(.DATA_W(DATA_W)) dut (
    .Clock   (clk),
    .Reset_b (rst_n),
    .bus     (bus)
  );

  typedef struct {
    func_e      fn;
    logic [3:0] data;
    logic       go;
    logic [7:0] exp_alu;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t v(func_e fn, logic [3:0] data, logic go,
                             logic [7:0] alu, logic busy, logic done,
                             logic ovf);
    vec_t r;
    r.fn = fn; r.data = data; r.go = go;
    r.exp_alu = alu; r.exp_busy = busy; r.exp_done = done; r.exp_ovf = ovf;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [7:0] alu, logic busy,
                           logic done, logic ovf);
    check({tag, " ALUout"}, 32'(bus.ALUout), 32'(alu));
    check({tag, " Busy"},   32'(bus.Busy),   32'(busy));
    check({tag, " Done"},   32'(bus.Done),   32'(done));
    check({tag, " Ovf"},    32'(bus.Ovf),    32'(ovf));
  endtask

  // Present inputs, take one posedge, settle to the checking point.
  task automatic step(logic go, func_e fn, logic [3:0] data);
    bus.Go       = go;
    bus.Function = fn;
    bus.Data     = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.Go       = 1'b0;
    bus.Function = HOLD;
    bus.Data     = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // ---- reset after random activity, with Ovf set and MUL running ----
    for (int i = 0; i < 8; i++)
      step(1'b1, func_e'(3'($urandom_range(7))), 4'($urandom_range(15)));
    repeat (5) step(1'b0, HOLD, 4'h0);       // let any multiply finish
    step(1'b1, LOAD, 4'hF);
    step(1'b1, SHL,  4'h4);                  // 0xF0
    step(1'b1, ACC,  4'hF);                  // 0xFF
    step(1'b1, ACC,  4'hF);                  // 0x10E -> 0x0E, Ovf
    check_all("pre-reset", 8'h0E, 1'b0, 1'b1, 1'b1);
    step(1'b1, MUL,  4'h3);
    check("pre-reset busy", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    step(1'b1, LOAD, 4'h5);                  // reset wins over Go
    check_all("reset-mid", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, HOLD, 4'h0);
      check_all($sformatf("post-reset%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // ---- table-driven vectors (state starts at 0, Ovf=0) ----
    //            fn    A     go    ALUout busy done ovf
    vecs.push_back(v(LOAD, 4'h5, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(ADD,  4'h3, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(ADD,  4'h3, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0));
    vecs.push_back(v(HOLD, 4'h9, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0));
    // MUL 7*9 with Go+CLR pushed while busy
    vecs.push_back(v(LOAD, 4'h7, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(MUL,  4'h9, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(CLR,  4'h0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(CLR,  4'h0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(CLR,  4'h0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(CLR,  4'h0, 1'b1, 8'h3F, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(CLR,  4'h0, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0));
    // shifts and their out-of-range cases
    vecs.push_back(v(LOAD, 4'h3, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(SHL,  4'h2, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(SHR,  4'h1, 1'b1, 8'h06, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(SHL,  4'h8, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(LOAD, 4'h9, 1'b1, 8'h09, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(SHL,  4'h4, 1'b1, 8'h90, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(SHR,  4'h4, 1'b1, 8'h09, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(SHR,  4'hF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0));
    // 15*15, back-to-back accumulate, sticky overflow
    vecs.push_back(v(LOAD, 4'hF, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(MUL,  4'hF, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(HOLD, 4'h0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(HOLD, 4'h0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(HOLD, 4'h0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v(HOLD, 4'h0, 1'b0, 8'hE1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(ACC,  4'hF, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(ACC,  4'hF, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(ACC,  4'h1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1));
    vecs.push_back(v(ADD,  4'h0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1));
    vecs.push_back(v(LOAD, 4'h2, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(LOAD, 4'hF, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(SHL,  4'h4, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(ACC,  4'hF, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v(ACC,  4'hF, 1'b1, 8'h0E, 1'b0, 1'b1, 1'b1));
    vecs.push_back(v(SHR,  4'h1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1));
    vecs.push_back(v(CLR,  4'h0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0));

    foreach (vecs[i]) begin
      step(vecs[i].go, vecs[i].fn, vecs[i].data);
      check_all($sformatf("vec%0d %s", i, vecs[i].fn.name()),
                vecs[i].exp_alu, vecs[i].exp_busy, vecs[i].exp_done,
                vecs[i].exp_ovf);
    end

    // ---- reset on the second busy cycle aborts the multiply ----
    step(1'b1, LOAD, 4'h7);
    step(1'b1, MUL,  4'h9);
    check("abort busy1", 32'(bus.Busy), 32'd1);
    step(1'b0, HOLD, 4'h0);
    check_all("abort busy2", 8'h07, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, HOLD, 4'h0);
    check_all("abort reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, HOLD, 4'h0);
      check_all($sformatf("abort after%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_alu_accum_reg
